// File: rtl/alu_pkg.sv
// ALU operation encoding shared by the decoder and the ALU datapath.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_PASS = 3'd0,
      ALU_ADD  = 3'd1,
      ALU_SUB  = 3'd2,
      ALU_AND  = 3'd3,
      ALU_OR   = 3'd4,
      ALU_XOR  = 3'd5,
      ALU_SHL  = 3'd6,
      ALU_SHR  = 3'd7
   } alu_op_t;

endpackage

// File: rtl/id_pkg.sv
// Opcode, instruction-class and FSM state types for the sequential instruction decoder.
package id_pkg;

   localparam int unsigned OPC_W    = 4;
   localparam int unsigned ALU_OP_W = 3;

   typedef enum logic [OPC_W-1:0] {
      OPC_NOP   = 4'h0,
      OPC_ALU1  = 4'h1,
      OPC_ALU2  = 4'h2,
      OPC_ALU3  = 4'h3,
      OPC_ALU4  = 4'h4,
      OPC_ALU5  = 4'h5,
      OPC_ALU6  = 4'h6,
      OPC_ALU7  = 4'h7,
      OPC_LOAD  = 4'h8,
      OPC_STORE = 4'h9,
      OPC_LOADI = 4'hA,
      OPC_ILLB  = 4'hB,
      OPC_ILLC  = 4'hC,
      OPC_ILLD  = 4'hD,
      OPC_ILLE  = 4'hE,
      OPC_HALT  = 4'hF
   } cpu_instructions_t;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_EXEC,
      ST_WAIT,
      ST_HALT
   } id_state_t;

   typedef enum logic [2:0] {
      CLS_NOP,
      CLS_ALU,
      CLS_LOAD,
      CLS_STORE,
      CLS_LOADI,
      CLS_HALT,
      CLS_ILLEGAL
   } id_class_t;

endpackage

// File: rtl/id_field_decode.sv
// Combinational classifier: maps an instruction word to its class and extracts operand fields.
module id_field_decode
   import id_pkg::*;
   import alu_pkg::*;
#(
   parameter int unsigned IW    = 16,
   parameter int unsigned RA_W  = 2,
   parameter int unsigned IMM_W = 8
) (
   input  logic [IW-1:0]    instr_i,
   output id_class_t        cls_o,
   output alu_op_t          alu_op_o,
   output logic [RA_W-1:0]  dst_o,
   output logic [RA_W-1:0]  src_o,
   output logic [IMM_W-1:0] imm_o
);

   cpu_instructions_t opc;
   logic              unused_bits;

   assign opc         = cpu_instructions_t'(instr_i[IW-1 -: OPC_W]);
   assign alu_op_o    = alu_op_t'(instr_i[IW-OPC_W +: ALU_OP_W]);
   assign dst_o       = instr_i[IW-1-OPC_W -: RA_W];
   assign src_o       = instr_i[RA_W-1:0];
   assign imm_o       = instr_i[IMM_W-1:0];
   assign unused_bits = ^instr_i;

   always_comb begin
      cls_o = CLS_ILLEGAL;
      case (opc)
         OPC_NOP:   cls_o = CLS_NOP;
         OPC_ALU1, OPC_ALU2, OPC_ALU3, OPC_ALU4,
         OPC_ALU5, OPC_ALU6, OPC_ALU7:
                    cls_o = CLS_ALU;
         OPC_LOAD:  cls_o = CLS_LOAD;
         OPC_STORE: cls_o = CLS_STORE;
         OPC_LOADI: cls_o = CLS_LOADI;
         OPC_HALT:  cls_o = CLS_HALT;
         default:   cls_o = CLS_ILLEGAL;
      endcase
   end

endmodule

// File: rtl/id_ctrl_seq.sv
// Sequential instruction decoder: valid/ready intake, one-cycle registered control pulses,
// optional wait on a multi-cycle ALU, HALT, illegal-opcode flag and retired-instruction counter.
module id_ctrl_seq
   import id_pkg::*;
   import alu_pkg::*;
#(
   parameter int unsigned IW       = 16,
   parameter int unsigned RA_W     = 2,
   parameter int unsigned IMM_W    = 8,
   parameter int unsigned ALU_WAIT = 0,
   parameter int unsigned CNT_W    = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [IW-1:0]       instr_i,
   input  logic                instr_valid_i,
   output logic                instr_ready_o,
   output logic [ALU_OP_W-1:0] alu_opcode_o,
   output logic                alu_ce_o,
   input  logic                alu_done_i,
   output logic [RA_W-1:0]     rf_addr_o,
   output logic                rf_we_o,
   output logic                a_re_o,
   output logic                a_we_o,
   output logic                imm_sel_o,
   output logic [IMM_W-1:0]    imm_o,
   output logic                halted_o,
   output logic                illegal_o,
   output logic [CNT_W-1:0]    retired_cnt_o
);

   id_class_t        dec_cls;
   alu_op_t          dec_alu_op;
   logic [RA_W-1:0]  dec_dst, dec_src;
   logic [IMM_W-1:0] dec_imm;

   id_state_t        state_q, state_d;
   id_class_t        cls_q, cls_d;
   alu_op_t          alu_op_q, alu_op_d;
   logic [RA_W-1:0]  rf_addr_q, rf_addr_d;
   logic [IMM_W-1:0] imm_q, imm_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ready_q, ready_d;
   logic             alu_ce_q, alu_ce_d;
   logic             rf_we_q, rf_we_d;
   logic             a_re_q, a_re_d;
   logic             a_we_q, a_we_d;
   logic             imm_sel_q, imm_sel_d;
   logic             halted_q, halted_d;
   logic             illegal_q, illegal_d;
   logic             retire;

   id_field_decode #(
      .IW    (IW),
      .RA_W  (RA_W),
      .IMM_W (IMM_W)
   ) u_field_decode (
      .instr_i  (instr_i),
      .cls_o    (dec_cls),
      .alu_op_o (dec_alu_op),
      .dst_o    (dec_dst),
      .src_o    (dec_src),
      .imm_o    (dec_imm)
   );

   // Pulses are computed at the accepting edge so they appear, registered, during EXEC.
   always_comb begin
      state_d   = state_q;
      cls_d     = cls_q;
      alu_op_d  = ALU_PASS;
      rf_addr_d = '0;
      imm_d     = '0;
      alu_ce_d  = 1'b0;
      rf_we_d   = 1'b0;
      a_re_d    = 1'b0;
      a_we_d    = 1'b0;
      imm_sel_d = 1'b0;
      illegal_d = 1'b0;
      retire    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (instr_valid_i && ready_q) begin
               state_d = ST_EXEC;
               cls_d   = dec_cls;
               case (dec_cls)
                  CLS_NOP: retire = 1'b1;
                  CLS_ALU: begin
                     alu_ce_d  = 1'b1;
                     alu_op_d  = dec_alu_op;
                     rf_addr_d = dec_src;
                     a_re_d    = 1'b1;
                     if (ALU_WAIT == 0) begin
                        a_we_d = 1'b1;
                        retire = 1'b1;
                     end
                  end
                  CLS_LOAD: begin
                     rf_addr_d = dec_src;
                     a_we_d    = 1'b1;
                     retire    = 1'b1;
                  end
                  CLS_STORE: begin
                     rf_addr_d = dec_dst;
                     a_re_d    = 1'b1;
                     rf_we_d   = 1'b1;
                     retire    = 1'b1;
                  end
                  CLS_LOADI: begin
                     a_we_d    = 1'b1;
                     imm_sel_d = 1'b1;
                     imm_d     = dec_imm;
                     retire    = 1'b1;
                  end
                  CLS_HALT: retire = 1'b1;
                  default:  illegal_d = 1'b1;
               endcase
            end
         end
         ST_EXEC: begin
            if ((cls_q == CLS_ALU) && (ALU_WAIT != 0)) begin
               state_d = ST_WAIT;
            end else if (cls_q == CLS_HALT) begin
               state_d = ST_HALT;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WAIT: begin
            if (alu_done_i) begin
               a_we_d  = 1'b1;
               retire  = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_HALT: state_d = ST_HALT;
         default: state_d = ST_IDLE;
      endcase

      halted_d = (state_d == ST_HALT);
      ready_d  = (state_d == ST_IDLE);
      cnt_d    = retire ? cnt_q + CNT_W'(1) : cnt_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         cls_q     <= CLS_NOP;
         alu_op_q  <= ALU_PASS;
         rf_addr_q <= '0;
         imm_q     <= '0;
         cnt_q     <= '0;
         ready_q   <= 1'b1;
         alu_ce_q  <= 1'b0;
         rf_we_q   <= 1'b0;
         a_re_q    <= 1'b0;
         a_we_q    <= 1'b0;
         imm_sel_q <= 1'b0;
         halted_q  <= 1'b0;
         illegal_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cls_q     <= cls_d;
         alu_op_q  <= alu_op_d;
         rf_addr_q <= rf_addr_d;
         imm_q     <= imm_d;
         cnt_q     <= cnt_d;
         ready_q   <= ready_d;
         alu_ce_q  <= alu_ce_d;
         rf_we_q   <= rf_we_d;
         a_re_q    <= a_re_d;
         a_we_q    <= a_we_d;
         imm_sel_q <= imm_sel_d;
         halted_q  <= halted_d;
         illegal_q <= illegal_d;
      end
   end

   // Ready is withheld while reset is asserted.
   assign instr_ready_o = ready_q & ~rst;
   assign alu_opcode_o  = alu_op_q;
   assign alu_ce_o      = alu_ce_q;
   assign rf_addr_o     = rf_addr_q;
   assign rf_we_o       = rf_we_q;
   assign a_re_o        = a_re_q;
   assign a_we_o        = a_we_q;
   assign imm_sel_o     = imm_sel_q;
   assign imm_o         = imm_q;
   assign halted_o      = halted_q;
   assign illegal_o     = illegal_q;
   assign retired_cnt_o = cnt_q;

endmodule

// File: tb/tb_id_ctrl_seq.sv
// Bench for id_ctrl_seq: single-cycle ALU instance (a) and waiting-ALU, 4-bit-counter instance (b).
module tb_id_ctrl_seq;

   typedef struct packed {
      logic       alu_ce;
      logic [2:0] alu_op;
      logic [1:0] rf_addr;
      logic       rf_we;
      logic       a_re;
      logic       a_we;
      logic       imm_sel;
      logic [7:0] imm;
      logic       illegal;
   } exp_t;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        a_rst, a_valid, a_done, a_ready, a_alu_ce, a_rf_we, a_a_re, a_a_we;
   logic        a_imm_sel, a_halted, a_illegal;
   logic [15:0] a_instr, a_cnt;
   logic [2:0]  a_alu_op;
   logic [1:0]  a_rf_addr;
   logic [7:0]  a_imm;

   logic        b_rst, b_valid, b_done, b_ready, b_alu_ce, b_rf_we, b_a_re, b_a_we;
   logic        b_imm_sel, b_halted, b_illegal;
   logic [15:0] b_instr;
   logic [3:0]  b_cnt;
   logic [2:0]  b_alu_op;
   logic [1:0]  b_rf_addr;
   logic [7:0]  b_imm;

   exp_t a_obs, b_obs, e, we_only;
   assign a_obs = {a_alu_ce, a_alu_op, a_rf_addr, a_rf_we, a_a_re, a_a_we, a_imm_sel, a_imm, a_illegal};
   assign b_obs = {b_alu_ce, b_alu_op, b_rf_addr, b_rf_we, b_a_re, b_a_we, b_imm_sel, b_imm, b_illegal};

   int checks = 0;
   int errors = 0;
   int cnt_a  = 0;
   int cnt_b  = 0;

   logic [15:0] directed [6] = '{16'h9C00, 16'hA05A, 16'h8002, 16'hB000, 16'h0000, 16'h3001};

   id_ctrl_seq #(.IW(16), .RA_W(2), .IMM_W(8), .ALU_WAIT(0), .CNT_W(16)) dut_a (
      .clk(clk), .rst(a_rst), .instr_i(a_instr), .instr_valid_i(a_valid), .instr_ready_o(a_ready),
      .alu_opcode_o(a_alu_op), .alu_ce_o(a_alu_ce), .alu_done_i(a_done), .rf_addr_o(a_rf_addr),
      .rf_we_o(a_rf_we), .a_re_o(a_a_re), .a_we_o(a_a_we), .imm_sel_o(a_imm_sel), .imm_o(a_imm),
      .halted_o(a_halted), .illegal_o(a_illegal), .retired_cnt_o(a_cnt));

   id_ctrl_seq #(.IW(16), .RA_W(2), .IMM_W(8), .ALU_WAIT(1), .CNT_W(4)) dut_b (
      .clk(clk), .rst(b_rst), .instr_i(b_instr), .instr_valid_i(b_valid), .instr_ready_o(b_ready),
      .alu_opcode_o(b_alu_op), .alu_ce_o(b_alu_ce), .alu_done_i(b_done), .rf_addr_o(b_rf_addr),
      .rf_we_o(b_rf_we), .a_re_o(b_a_re), .a_we_o(b_a_we), .imm_sel_o(b_imm_sel), .imm_o(b_imm),
      .halted_o(b_halted), .illegal_o(b_illegal), .retired_cnt_o(b_cnt));

   // Reference: the pulse set each opcode must produce in the cycle after acceptance.
   function automatic exp_t model_pulses(input logic [15:0] ins, input bit alu_wait);
      exp_t r;
      int   op;
      r  = '0;
      op = int'(ins[15:12]);
      if (op >= 1 && op <= 7) begin
         r.alu_ce  = 1'b1;
         r.alu_op  = ins[14:12];
         r.rf_addr = ins[1:0];
         r.a_re    = 1'b1;
         r.a_we    = !alu_wait;
      end else if (op == 8) begin
         r.rf_addr = ins[1:0];
         r.a_we    = 1'b1;
      end else if (op == 9) begin
         r.rf_addr = ins[11:10];
         r.a_re    = 1'b1;
         r.rf_we   = 1'b1;
      end else if (op == 10) begin
         r.a_we    = 1'b1;
         r.imm_sel = 1'b1;
         r.imm     = ins[7:0];
      end else if (op >= 11 && op <= 14) begin
         r.illegal = 1'b1;
      end
      return r;
   endfunction

   function automatic bit retires(input logic [15:0] ins);
      int op;
      op = int'(ins[15:12]);
      return !(op >= 11 && op <= 14);
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      a_rst = 1'b1; b_rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0;
      a_done = 1'b0; b_done = 1'b0; a_instr = '0; b_instr = '0;
      tick();
      checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_during_rst got %b exp 0", a_ready); end
      tick();
      a_rst = 1'b0; b_rst = 1'b0;
      #1;
      checks++; if (a_obs !== '0) begin errors++; $display("FAIL reset_a_outputs got %h exp 0", a_obs); end
      checks++; if (a_ready !== 1'b1 || a_halted !== 1'b0) begin errors++; $display("FAIL reset_a_ready_halted got %b%b exp 10", a_ready, a_halted); end
      checks++; if (a_cnt !== 16'd0) begin errors++; $display("FAIL reset_a_cnt got %0d exp 0", a_cnt); end
      checks++; if (b_obs !== '0 || b_ready !== 1'b1 || b_cnt !== 4'd0) begin errors++; $display("FAIL reset_b got %h %b %0d exp 0 1 0", b_obs, b_ready, b_cnt); end
      cnt_a = 0; cnt_b = 0;
   endtask

   task automatic test_directed_ops();
      logic [15:0] ins;
      for (int i = 0; i < 6; i++) begin
         ins = directed[i];
         checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL dir_ready_before %h got %b exp 1", ins, a_ready); end
         a_instr = ins; a_valid = 1'b1;
         tick();
         a_valid = 1'b0; a_instr = '0;
         e = model_pulses(ins, 1'b0);
         checks++; if (a_obs !== e) begin errors++; $display("FAIL dir_pulse %h got %h exp %h", ins, a_obs, e); end
         checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL dir_ready_exec %h got %b exp 0", ins, a_ready); end
         if (retires(ins)) cnt_a = (cnt_a + 1) % 65536;
         tick();
         checks++; if (a_obs !== '0 || a_ready !== 1'b1) begin errors++; $display("FAIL dir_after %h got %h %b exp 0 1", ins, a_obs, a_ready); end
         checks++; if (a_cnt !== 16'(cnt_a)) begin errors++; $display("FAIL dir_cnt %h got %0d exp %0d", ins, a_cnt, cnt_a); end
      end
      checks++; if (a_cnt !== 16'd5) begin errors++; $display("FAIL dir_total_cnt got %0d exp 5", a_cnt); end
   endtask

   task automatic test_random_ops();
      logic [15:0] ins;
      int          gap;
      for (int i = 0; i < 40; i++) begin
         ins = {4'($urandom_range(0, 14)), 12'($urandom)};
         a_done = 1'($urandom);
         a_instr = ins; a_valid = 1'b1;
         tick();
         a_valid = 1'b0; a_instr = 16'($urandom);
         e = model_pulses(ins, 1'b0);
         checks++; if (a_obs !== e) begin errors++; $display("FAIL rnd_pulse %h got %h exp %h", ins, a_obs, e); end
         if (retires(ins)) cnt_a = (cnt_a + 1) % 65536;
         gap = $urandom_range(1, 3);
         for (int g = 0; g < gap; g++) begin
            tick();
            checks++; if (a_obs !== '0 || a_ready !== 1'b1) begin errors++; $display("FAIL rnd_idle %h got %h %b exp 0 1", ins, a_obs, a_ready); end
         end
         checks++; if (a_cnt !== 16'(cnt_a)) begin errors++; $display("FAIL rnd_cnt %h got %0d exp %0d", ins, a_cnt, cnt_a); end
      end
      a_done = 1'b0;
   endtask

   task automatic test_alu_wait();
      logic [15:0] ins;
      int          nwait;
      we_only      = '0;
      we_only.a_we = 1'b1;
      for (int k = 0; k < 6; k++) begin
         ins   = (k == 0) ? 16'h3001 : {1'b0, 3'($urandom_range(1, 7)), 12'($urandom)};
         nwait = (k == 0) ? 4 : $urandom_range(0, 3);
         checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL wait_ready_before %h got %b exp 1", ins, b_ready); end
         b_instr = ins; b_valid = 1'b1; b_done = 1'(k & 1);
         tick();
         b_valid = 1'b0;
         e = model_pulses(ins, 1'b1);
         checks++; if (b_obs !== e || b_ready !== 1'b0) begin errors++; $display("FAIL wait_exec %h got %h %b exp %h 0", ins, b_obs, b_ready, e); end
         tick();
         b_done = 1'b0;
         checks++; if (b_obs !== '0 || b_ready !== 1'b0) begin errors++; $display("FAIL wait_enter %h got %h %b exp 0 0", ins, b_obs, b_ready); end
         for (int w = 0; w < nwait; w++) begin
            tick();
            checks++; if (b_obs !== '0 || b_ready !== 1'b0) begin errors++; $display("FAIL wait_hold %h got %h %b exp 0 0", ins, b_obs, b_ready); end
         end
         b_done = 1'b1;
         tick();
         b_done = 1'b0;
         cnt_b = (cnt_b + 1) % 16;
         checks++; if (b_obs !== we_only) begin errors++; $display("FAIL wait_done_we %h got %h exp %h", ins, b_obs, we_only); end
         checks++; if (b_cnt !== 4'(cnt_b) || b_ready !== 1'b1) begin errors++; $display("FAIL wait_done_cnt %h got %0d %b exp %0d 1", ins, b_cnt, b_ready, cnt_b); end
         tick();
         checks++; if (b_obs !== '0) begin errors++; $display("FAIL wait_after %h got %h exp 0", ins, b_obs); end
      end
   endtask

   task automatic test_halt();
      a_instr = 16'hF000; a_valid = 1'b1;
      tick();
      a_valid = 1'b0;
      cnt_a = (cnt_a + 1) % 65536;
      checks++; if (a_obs !== '0 || a_halted !== 1'b0) begin errors++; $display("FAIL halt_exec got %h %b exp 0 0", a_obs, a_halted); end
      tick();
      checks++; if (a_halted !== 1'b1 || a_ready !== 1'b0) begin errors++; $display("FAIL halt_state got %b %b exp 1 0", a_halted, a_ready); end
      checks++; if (a_cnt !== 16'(cnt_a)) begin errors++; $display("FAIL halt_cnt got %0d exp %0d", a_cnt, cnt_a); end
      a_instr = 16'h9C00; a_valid = 1'b1; a_done = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         checks++; if (a_halted !== 1'b1 || a_ready !== 1'b0 || a_obs !== '0 || a_cnt !== 16'(cnt_a)) begin
            errors++; $display("FAIL halt_ignore got %b %b %h %0d exp 1 0 0 %0d", a_halted, a_ready, a_obs, a_cnt, cnt_a);
         end
      end
      a_valid = 1'b0; a_done = 1'b0; a_rst = 1'b1;
      tick();
      a_rst = 1'b0;
      #1;
      cnt_a = 0;
      checks++; if (a_halted !== 1'b0 || a_ready !== 1'b1 || a_cnt !== 16'd0 || a_obs !== '0) begin
         errors++; $display("FAIL halt_reset got %b %b %0d %h exp 0 1 0 0", a_halted, a_ready, a_cnt, a_obs);
      end
   endtask

   task automatic test_back_to_back();
      b_rst = 1'b1;
      tick();
      b_rst = 1'b0;
      #1;
      cnt_b = 0;
      b_instr = 16'h0000; b_valid = 1'b1;
      for (int i = 0; i < 17; i++) begin
         checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_hi %0d got %b exp 1", i, b_ready); end
         tick();
         checks++; if (b_ready !== 1'b0 || b_obs !== '0) begin errors++; $display("FAIL b2b_exec %0d got %b %h exp 0 0", i, b_ready, b_obs); end
         tick();
         cnt_b = (cnt_b + 1) % 16;
         checks++; if (b_cnt !== 4'(cnt_b)) begin errors++; $display("FAIL b2b_cnt %0d got %0d exp %0d", i, b_cnt, cnt_b); end
      end
      b_valid = 1'b0;
      checks++; if (b_cnt !== 4'd1) begin errors++; $display("FAIL b2b_wrap got %0d exp 1", b_cnt); end
   endtask

   task automatic test_reset_in_wait();
      b_instr = 16'h5002; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      tick();
      checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL rstw_in_wait got %b exp 0", b_ready); end
      b_rst = 1'b1;
      tick();
      b_rst = 1'b0;
      #1;
      cnt_b = 0;
      checks++; if (b_obs !== '0 || b_ready !== 1'b1 || b_halted !== 1'b0 || b_cnt !== 4'd0) begin
         errors++; $display("FAIL rstw_after got %h %b %b %0d exp 0 1 0 0", b_obs, b_ready, b_halted, b_cnt);
      end
      b_done = 1'b1;
      tick();
      b_done = 1'b0;
      checks++; if (b_obs !== '0 || b_cnt !== 4'd0) begin errors++; $display("FAIL rstw_done_ignored got %h %0d exp 0 0", b_obs, b_cnt); end
      b_instr = 16'h0000; b_valid = 1'b1;
      tick();
      b_valid = 1'b0;
      tick();
      checks++; if (b_cnt !== 4'd1 || b_ready !== 1'b1) begin errors++; $display("FAIL rstw_nop got %0d %b exp 1 1", b_cnt, b_ready); end
   endtask

   initial begin
      test_reset();
      test_directed_ops();
      test_random_ops();
      test_halt();
      test_alu_wait();
      test_back_to_back();
      test_reset_in_wait();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
